mips_trace_buffer: RTL and testbench
====================================

Name: mips_trace_buffer

Overview:
- Post-trigger trace capture block sitting directly downstream of the MIPS pipeline top.
- Consumes its per-cycle debug outputs (PC, instruction, ALU result, flags, stall) and records retired-cycle snapshots into a circular buffer.
- Freezes a programmable number of records after a PC-match trigger.
- Drains the frozen records over a valid/ready readout port for the bench or a debug UART.

Parameters:
DEPTH, 16, number of trace records; power of two, >= 4.
POST_TRIG, 8, records captured after the trigger record before freezing; 0 .. DEPTH-1.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ip_PC  input  10  PC from the pipeline
ip_instruction  input  32  instruction from the pipeline
ip_ALU_result  input  32  ALU result from the pipeline
ip_RegWrite  input  1  RegWrite flag
ip_MemWrite  input  1  MemWrite flag
ip_Branch  input  1  Branch flag
ip_Zero  input  1  Zero flag
ip_stall  input  1  pipeline stall; no capture while high
ip_arm  input  1  single-cycle pulse to start a capture session
ip_trigger_en  input  1  enables PC-match trigger
ip_trigger_PC  input  10  trigger PC value
ip_rd_ready  input  1  readout consumer ready
op_rd_valid  output  1  readout record valid
op_rd_data  output  78  record {PC[9:0], RegWrite, MemWrite, Branch, Zero, instruction[31:0], ALU_result[31:0]}
op_count  output  clog2(DEPTH)+1  records held
op_dropped  output  8  records overwritten this session, saturates at 255
op_state  output  2  0=IDLE, 1=ARMED, 2=POST, 3=FROZEN

Behaviour:
- Reset (synchronous, active-high, highest priority, any state):
  - state=IDLE; wr_ptr=rd_ptr=0; op_count=0; op_dropped=0; post counter=0.
  - op_rd_valid=0; op_rd_data is don't-care while not valid.
- Capture event `cap`: state in {ARMED, POST} and ip_stall==0 (further qualified by the optional feature). Each `cap` writes one record at wr_ptr, and wr_ptr increments modulo DEPTH.
- IDLE:
  - ip_arm=1 -> clear pointers, count and dropped; go to ARMED next cycle.
  - No capture.
  - ip_arm in any state other than IDLE is ignored.
- ARMED (circular capture):
  - On `cap` with count<DEPTH: count+1.
  - On `cap` with count==DEPTH: overwrite the oldest record, rd_ptr+1, count unchanged, op_dropped+1 (saturating).
  - Trigger = `cap` && ip_trigger_en && ip_PC==ip_trigger_PC. The triggering record is captured.
  - On trigger: load post counter=POST_TRIG; go to POST, or directly to FROZEN if POST_TRIG==0.
- POST:
  - Each `cap` captures as in ARMED (overwrite rules included) and decrements the post counter.
  - The capture that takes the counter to 0 is the last capture; next state is FROZEN.
  - The PC comparator is ignored in POST.
- FROZEN:
  - No capture.
  - op_rd_valid = (count!=0).
  - op_rd_data = record at rd_ptr, first-word fall-through (combinational from storage).
  - Handshake: when op_rd_valid && ip_rd_ready at an edge: rd_ptr+1, count-1.
  - While ip_rd_ready=0, op_rd_data and op_count are held stable.
  - Record order is oldest first.
  - When the last record pops (count 1->0): go to IDLE. If count==0 on entry (impossible unless DEPTH misconfigured), go to IDLE.
- op_rd_valid is 0 in IDLE, ARMED and POST.
- Push and pop never occur in the same cycle, by construction of the states.
- Pointers use clog2(DEPTH) bits and wrap naturally. Count is a separate clog2(DEPTH)+1-bit register.
- op_state, op_count and op_dropped are registered outputs.
- Storage: inferred register array, no reset required on the array contents.

Optional Feature:
Macro: TRACE_FILTER_EN
- Defined: `cap` additionally requires (ip_RegWrite | ip_MemWrite | ip_Branch). Bubbles and no-op cycles are not recorded. The trigger is also evaluated only on qualified cycles.
- Undefined: every non-stalled cycle in ARMED/POST is captured.

Test Plan:
1. Assert reset for 2 cycles mid-stream -> op_state=0, op_count=0, op_dropped=0, op_rd_valid=0.
2. DEPTH=16, POST_TRIG=8: arm; PCs 0x000,0x004,... one per cycle; trigger_PC=0x010 (5th capture) -> FROZEN after 13 captures, op_count=13, op_dropped=0. Drain with ready=1 -> PCs 0x000..0x030 in order; IDLE after 13th handshake.
3. Wrap: arm; trigger on 31st capture; 8 post captures (39 total) -> op_count=16, op_dropped=23, first record read = capture #24.
4. Stall: in ARMED hold ip_stall=1 for 5 cycles with changing PC -> op_count unchanged, no trigger even if the PC matches during the stall.
5. Backpressure: FROZEN with count=13, ip_rd_ready=0 for 4 cycles -> op_rd_valid=1, op_rd_data and op_count stable. Raise ready -> one pop per cycle.
6. Reset during POST -> IDLE, count 0. ip_arm pulse while ARMED -> ignored (op_count keeps its value). With TRACE_FILTER_EN defined, 3 cycles with all flags 0 -> no capture.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer
// Post-trigger trace capture for the MIPS pipeline debug outputs.
// Records non-stalled cycles into a circular buffer once armed, keeps
// POST_TRIG records after a PC-match trigger, then freezes and drains the
// frozen records oldest first over a valid/ready port.
//
// Optional build macro: TRACE_FILTER_EN
//   When defined, only cycles with RegWrite, MemWrite or Branch set are
//   captured (and considered for the trigger).
//
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   ip_PC .. ip_Zero   : per-cycle pipeline snapshot to record
//   ip_stall           : no capture while high
//   ip_arm             : pulse in IDLE starts a capture session
//   ip_trigger_en/PC   : PC-match trigger
//   ip_rd_ready        : readout consumer ready
//   op_rd_valid/data   : readout record (fall-through from storage)
//   op_count           : records held
//   op_dropped         : records overwritten this session (saturating)
//   op_state           : 0=IDLE 1=ARMED 2=POST 3=FROZEN
module mips_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [9:0]                 ip_PC,
    input  logic [31:0]                ip_instruction,
    input  logic [31:0]                ip_ALU_result,
    input  logic                       ip_RegWrite,
    input  logic                       ip_MemWrite,
    input  logic                       ip_Branch,
    input  logic                       ip_Zero,
    input  logic                       ip_stall,
    input  logic                       ip_arm,
    input  logic                       ip_trigger_en,
    input  logic [9:0]                 ip_trigger_PC,
    input  logic                       ip_rd_ready,
    output logic                       op_rd_valid,
    output logic [77:0]                op_rd_data,
    output logic [$clog2(DEPTH):0]     op_count,
    output logic [7:0]                 op_dropped,
    output logic [1:0]                 op_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PT   = AW'(POST_TRIG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_post;
    logic [AW:0]   r_count;
    logic [7:0]    r_dropped;
    logic [77:0]   r_mem [DEPTH];

    logic w_qual, w_cap, w_trig, w_pop;

`ifdef TRACE_FILTER_EN
    assign w_qual = ip_RegWrite | ip_MemWrite | ip_Branch;
`else
    assign w_qual = 1'b1;
`endif

    assign w_cap  = (r_state == ARMED || r_state == POST) && !ip_stall && w_qual;
    // Comparator only matters while ARMED; POST ignores further matches.
    assign w_trig = w_cap && (r_state == ARMED) && ip_trigger_en && (ip_PC == ip_trigger_PC);
    assign w_pop  = op_rd_valid && ip_rd_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (ip_arm) w_next = ARMED;
            ARMED:  if (w_trig) w_next = (PT == '0) ? FROZEN : POST;
            POST:   if (w_cap && r_post == AW'(1)) w_next = FROZEN;
            FROZEN: if (r_count == '0 || (w_pop && r_count == (AW+1)'(1))) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
            r_post    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && ip_arm) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_dropped <= '0;
            end
            if (w_cap) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count != FULL) begin
                    r_count <= r_count + 1'b1;
                end else begin
                    // Full: the write lands on the oldest record.
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    if (r_dropped != 8'hFF) r_dropped <= r_dropped + 1'b1;
                end
                if (w_trig)
                    r_post <= PT;
                else if (r_state == POST)
                    r_post <= r_post - 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_cap)
            r_mem[r_wr_ptr] <= {ip_PC, ip_RegWrite, ip_MemWrite, ip_Branch, ip_Zero,
                                ip_instruction, ip_ALU_result};
    end

    assign op_rd_valid = (r_state == FROZEN) && (r_count != '0);
    assign op_rd_data  = r_mem[r_rd_ptr];
    assign op_count    = r_count;
    assign op_dropped  = r_dropped;
    assign op_state    = r_state;
endmodule

// File: tb/tb_mips_trace_buffer.sv
module tb_mips_trace_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  ip_PC;
    logic [31:0] ip_instruction, ip_ALU_result;
    logic        ip_RegWrite, ip_MemWrite, ip_Branch, ip_Zero, ip_stall;
    logic        ip_arm, ip_trigger_en, ip_rd_ready;
    logic [9:0]  ip_trigger_PC;
    logic        op_rd_valid;
    logic [77:0] op_rd_data;
    logic [4:0]  op_count;
    logic [7:0]  op_dropped;
    logic [1:0]  op_state;

    int checks = 0;
    int failures = 0;

    mips_trace_buffer #(.DEPTH(16), .POST_TRIG(8)) dut (
        .clock(clock), .reset(reset), .ip_PC(ip_PC), .ip_instruction(ip_instruction),
        .ip_ALU_result(ip_ALU_result), .ip_RegWrite(ip_RegWrite), .ip_MemWrite(ip_MemWrite),
        .ip_Branch(ip_Branch), .ip_Zero(ip_Zero), .ip_stall(ip_stall), .ip_arm(ip_arm),
        .ip_trigger_en(ip_trigger_en), .ip_trigger_PC(ip_trigger_PC), .ip_rd_ready(ip_rd_ready),
        .op_rd_valid(op_rd_valid), .op_rd_data(op_rd_data), .op_count(op_count),
        .op_dropped(op_dropped), .op_state(op_state)
    );

    always #5 clock = ~clock;

    // Expected record for a cycle driven with drive(pc).
    function automatic logic [77:0] rec(input logic [9:0] pc);
        return {pc, 1'b1, pc[2], pc[3], pc[4], {22'h2ABCD, pc}, {12'hC0D, pc, pc}};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [9:0] pc);
        ip_PC          = pc;
        ip_RegWrite    = 1'b1;
        ip_MemWrite    = pc[2];
        ip_Branch      = pc[3];
        ip_Zero        = pc[4];
        ip_instruction = {22'h2ABCD, pc};
        ip_ALU_result  = {12'hC0D, pc, pc};
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic arm();
        ip_arm = 1'b1;
        step();
        ip_arm = 1'b0;
    endtask

    // n captures with PC = 4*i, i = 0..n-1
    task automatic run_caps(input int n);
        for (int i = 0; i < n; i++) begin
            drive(10'(4 * i));
            step();
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (op_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", op_state); end
        // mid-stream reset
        ip_trigger_en = 1'b0;
        arm();
        run_caps(3);
        checks++; if (op_count !== 5'd3) begin failures++; $display("FAIL pre_reset_count got=%0d exp=3", op_count); end
        do_reset(2);
        checks++; if (op_state !== 2'd0) begin failures++; $display("FAIL mid_reset_state got=%0d exp=0", op_state); end
        checks++; if (op_count !== 5'd0) begin failures++; $display("FAIL mid_reset_count got=%0d exp=0", op_count); end
        checks++; if (op_dropped !== 8'd0) begin failures++; $display("FAIL mid_reset_dropped got=%0d exp=0", op_dropped); end
        checks++; if (op_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%0b exp=0", op_rd_valid); end
    endtask

    task automatic test_trigger_drain();
        ip_trigger_en = 1'b1;
        ip_trigger_PC = 10'h010;
        arm();
        checks++; if (op_state !== 2'd1) begin failures++; $display("FAIL arm_state got=%0d exp=1", op_state); end
        run_caps(5);
        checks++; if (op_state !== 2'd2) begin failures++; $display("FAIL post_state got=%0d exp=2", op_state); end
        run_caps(0);
        for (int i = 5; i < 13; i++) begin drive(10'(4 * i)); step(); end
        checks++; if (op_state !== 2'd3) begin failures++; $display("FAIL frozen_state got=%0d exp=3", op_state); end
        checks++; if (op_count !== 5'd13) begin failures++; $display("FAIL frozen_count got=%0d exp=13", op_count); end
        checks++; if (op_dropped !== 8'd0) begin failures++; $display("FAIL frozen_dropped got=%0d exp=0", op_dropped); end
        step();  // frozen: further cycles not captured
        checks++; if (op_count !== 5'd13) begin failures++; $display("FAIL frozen_hold got=%0d exp=13", op_count); end
        ip_rd_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            checks++;
            if (op_rd_valid !== 1'b1 || op_rd_data !== rec(10'(4 * k))) begin
                failures++;
                $display("FAIL drain_%0d got=%0b/%h exp=1/%h", k, op_rd_valid, op_rd_data, rec(10'(4 * k)));
            end
            step();
        end
        ip_rd_ready = 1'b0;
        checks++; if (op_state !== 2'd0 || op_rd_valid !== 1'b0) begin failures++; $display("FAIL drain_idle state=%0d valid=%0b exp=0/0", op_state, op_rd_valid); end
    endtask

    task automatic test_wrap();
        ip_trigger_en = 1'b1;
        ip_trigger_PC = 10'(4 * 30);
        arm();
        run_caps(39);
        checks++; if (op_state !== 2'd3) begin failures++; $display("FAIL wrap_state got=%0d exp=3", op_state); end
        checks++; if (op_count !== 5'd16) begin failures++; $display("FAIL wrap_count got=%0d exp=16", op_count); end
        checks++; if (op_dropped !== 8'd23) begin failures++; $display("FAIL wrap_dropped got=%0d exp=23", op_dropped); end
        ip_rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (op_rd_data !== rec(10'(4 * (23 + k)))) begin
                failures++;
                $display("FAIL wrap_rd_%0d got=%h exp=%h", k, op_rd_data, rec(10'(4 * (23 + k))));
            end
            step();
        end
        ip_rd_ready = 1'b0;
        checks++; if (op_state !== 2'd0) begin failures++; $display("FAIL wrap_idle got=%0d exp=0", op_state); end
    endtask

    task automatic test_saturate();
        ip_trigger_en = 1'b0;
        arm();
        run_caps(300);
        checks++; if (op_dropped !== 8'd255) begin failures++; $display("FAIL sat_dropped got=%0d exp=255", op_dropped); end
        checks++; if (op_count !== 5'd16) begin failures++; $display("FAIL sat_count got=%0d exp=16", op_count); end
        do_reset(1);
    endtask

    task automatic test_stall();
        ip_trigger_en = 1'b1;
        ip_trigger_PC = 10'h100;
        arm();
        run_caps(3);
        ip_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(10'h0F8 + 10'(4 * i));  // passes through 0x100
            step();
        end
        ip_stall = 1'b0;
        checks++; if (op_count !== 5'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", op_count); end
        checks++; if (op_state !== 2'd1) begin failures++; $display("FAIL stall_state got=%0d exp=1", op_state); end
        do_reset(1);
    endtask

    task automatic test_back_to_back();
        ip_trigger_en = 1'b1;
        ip_trigger_PC = 10'h010;
        arm();
        run_caps(13);
        ip_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (op_rd_valid !== 1'b1 || op_rd_data !== rec(10'h000) || op_count !== 5'd13) begin
                failures++;
                $display("FAIL bp_hold_%0d got=%0b/%h/%0d exp=1/%h/13", i, op_rd_valid, op_rd_data, op_count, rec(10'h000));
            end
        end
        ip_rd_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (op_count !== 5'(13 - k) || op_rd_data !== rec(10'(4 * k))) begin
                failures++;
                $display("FAIL bp_pop_%0d got=%0d/%h exp=%0d/%h", k, op_count, op_rd_data, 13 - k, rec(10'(4 * k)));
            end
        end
        ip_rd_ready = 1'b0;
        do_reset(1);
    endtask

    task automatic test_post_reset_arm();
        ip_trigger_en = 1'b1;
        ip_trigger_PC = 10'h008;
        arm();
        run_caps(4);
        checks++; if (op_state !== 2'd2) begin failures++; $display("FAIL pr_post got=%0d exp=2", op_state); end
        do_reset(1);
        checks++; if (op_state !== 2'd0 || op_count !== 5'd0) begin failures++; $display("FAIL pr_reset got=%0d/%0d exp=0/0", op_state, op_count); end
        ip_trigger_en = 1'b0;
        arm();
        run_caps(3);
        ip_stall = 1'b1;
        arm();
        ip_stall = 1'b0;
        checks++; if (op_count !== 5'd3 || op_state !== 2'd1) begin failures++; $display("FAIL arm_ignored got=%0d/%0d exp=3/1", op_count, op_state); end
`ifdef TRACE_FILTER_EN
        for (int i = 0; i < 3; i++) begin
            drive(10'h200);
            ip_RegWrite = 1'b0; ip_MemWrite = 1'b0; ip_Branch = 1'b0;
            step();
        end
        checks++; if (op_count !== 5'd3) begin failures++; $display("FAIL filter_count got=%0d exp=3", op_count); end
`endif
        do_reset(1);
    endtask

    initial begin
        reset = 1'b1; ip_arm = 1'b0; ip_stall = 1'b0; ip_trigger_en = 1'b0;
        ip_trigger_PC = '0; ip_rd_ready = 1'b0;
        drive(10'h000);
        test_reset();
        test_trigger_drain();
        test_wrap();
        test_saturate();
        test_stall();
        test_back_to_back();
        test_post_reset_arm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
